ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage MIPS pipeline. It consumes the ID/EX register outputs and performs ALU operations, shifts and set-less-than. It runs unsigned multiply/divide on an iterative unit with HI/LO registers, and resolves branches and jumps. Results and the memory/writeback control bits are registered into the EX/MEM latch that feeds the MEM stage. While a multiply/divide iterates, the stage raises a busy stall.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- ReadData1_in  in  32  rs operand.
- ReadData2_in  in  32  rt operand; also the store data.
- SignExtdNo_in  in  32  sign-extended immediate.
- IC_chunk_in  in  20  rs[19:15], rt[14:10], rd[9:5], shamt[4:0].
- ALUCntrl_in  in  4  operation select (encoding below).
- ALUSrc_in  in  1  1: operand B = SignExtdNo_in; 0: operand B = ReadData2_in.
- RegDest_in  in  1  1: destination = rd; 0: destination = rt.
- Branch_in  in  2  01 BEQ, 10 BNE, 00/11 no branch.
- Jump_in  in  1  jump.
- BranchAddr_in  in  32  branch target.
- JumpAddr_in  in  32  jump target.
- MemRead_in, MemWrite_in, MemToReg_in, RegWrite_in  in  1 each  downstream controls.
- ALUResult_out  out  32  registered result.
- WriteData_out  out  32  registered ReadData2_in.
- WriteReg_out  out  5  registered destination register.
- MemRead_out, MemWrite_out, MemToReg_out, RegWrite_out  out  1 each  registered controls.
- PCSrc_out  out  1  combinational redirect request.
- PCTarget_out  out  32  combinational redirect target.
- ex_busy  out  1  combinational stall; PC, IF/ID and ID/EX hold their contents while it is high.

## Operation
- Operand A is ReadData1_in. Operand B is selected by ALUSrc_in.
- ALUCntrl encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR; 0110 SUB.
  - 0101 SLL B by shamt; 1000 SRL B by shamt; 1001 SRA B by shamt.
  - 0111 SLT (signed); 1010 SLTU.
  - 1011 MULTU; 1100 DIVU; 1101 MFHI; 1110 MFLO.
  - 1111 result 0.
- Arithmetic is modulo 2^32 with no overflow trap. SLT/SLTU results are 32'd0 or 32'd1.
- Multiply/divide FSM has three states:
  - IDLE: an op of 1011 or 1100 is present → latch A and B, count = 0, go to BUSY.
  - BUSY: one iteration per cycle. MULTU is shift-add; DIVU is restoring division. When count = 31, write HI/LO and go to DONE.
  - DONE: the same op is still presented; go to IDLE. The op is not restarted.
- MULTU writes HI:LO = A*B as a 64-bit product.
- DIVU writes LO = quotient and HI = remainder. Divide by zero gives LO = 32'hFFFFFFFF, HI = A, with the same latency.
- MULTU/DIVU never write the register file. The EX/MEM entry they produce has RegWrite_out = 0, MemRead_out = 0, MemWrite_out = 0.
- Redirect logic:
  - Jump_in = 1 → PCSrc_out = 1, PCTarget_out = JumpAddr_in. Jump has priority over branch.
  - BEQ is taken when ReadData1_in == ReadData2_in; BNE when they differ. Taken → PCSrc_out = 1, PCTarget_out = BranchAddr_in.
  - Otherwise PCSrc_out = 0 and PCTarget_out = 0.

## Timing
- Reset, evaluated at posedge:
  - All registered outputs cleared to 0.
  - HI, LO, count and latched operands cleared to 0; FSM goes to IDLE.
  - A reset during BUSY abandons the operation; HI/LO end at 0.
- Single-cycle ops: an instruction presented in cycle n appears on the EX/MEM outputs after posedge n+1 (1-cycle latency).
- ex_busy = 1 when:
  - state is IDLE and ALUCntrl_in is 1011 or 1100, or
  - state is BUSY.
- ex_busy = 0 in DONE.
- MULTU/DIVU schedule:
  - Cycle 0 (IDLE) accepts the op.
  - Cycles 1–32 are BUSY; HI/LO update at the end of cycle 32.
  - Cycle 33 is DONE.
  - ex_busy is high for 33 cycles. Upstream advances at the end of cycle 33.
- Every cycle with ex_busy = 1 latches a bubble into EX/MEM: all controls 0, data 0.
- HI/LO are readable by an MFHI/MFLO presented in the cycle immediately after DONE, with no extra stall.
- PCSrc_out/PCTarget_out are purely combinational within the cycle. Flushing younger stages is handled outside this block.

## Test plan
- ADD, A = 5, immediate −3, ALUSrc = 1, RegDest = 0, rt = 9, RegWrite = 1 → after one edge: ALUResult_out = 2, WriteReg_out = 9, RegWrite_out = 1.
- SLT A = 0xFFFFFFFF, B = 1 → 1; SLTU on the same operands → 0; SRA B = 0x80000000, shamt 4 → 0xF8000000.
- MULTU 0xFFFFFFFF × 2 → ex_busy high for exactly 33 cycles, bubbles on EX/MEM, then HI = 1, LO = 0xFFFFFFFE. A following MFHI yields 1.
- DIVU 100 / 7 → LO = 14, HI = 2. DIVU 37 / 0 → LO = 0xFFFFFFFF, HI = 37, with the same 33-cycle busy.
- Reset asserted in BUSY cycle 10 → next edge: FSM IDLE, ex_busy = 0 (no new op presented), HI = LO = 0, all outputs 0.
- BEQ with equal operands, BranchAddr = 0x40 → PCSrc_out = 1, PCTarget_out = 0x40. The same with Jump_in = 1 and JumpAddr = 0x100 → target 0x100. BNE with equal operands → PCSrc_out = 0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ALU, shifts, set-less-than, iterative unsigned mul/div with
// HI/LO, branch/jump redirect, and the EX/MEM pipeline latch.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ReadData1_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] SignExtdNo_in,
  input  logic [19:0] IC_chunk_in,
  input  logic [3:0]  ALUCntrl_in,
  input  logic        ALUSrc_in,
  input  logic        RegDest_in,
  input  logic [1:0]  Branch_in,
  input  logic        Jump_in,
  input  logic [31:0] BranchAddr_in,
  input  logic [31:0] JumpAddr_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemToReg_in,
  input  logic        RegWrite_in,
  output logic [31:0] ALUResult_out,
  output logic [31:0] WriteData_out,
  output logic [4:0]  WriteReg_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic        MemToReg_out,
  output logic        RegWrite_out,
  output logic        PCSrc_out,
  output logic [31:0] PCTarget_out,
  output logic        ex_busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 5;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_MFHI = 4'b1101;
  localparam logic [3:0] OP_MFLO = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic            div_q, div_d;
  logic [2*DW-1:0] work_q, work_d;
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [DW-1:0]   alu_q, alu_d, wdata_q, wdata_d;
  logic [RW-1:0]   wreg_q, wreg_d;
  logic            mr_q, mr_d, mw_q, mw_d, mtr_q, mtr_d, rw_q, rw_d;

  logic [DW-1:0]   op_a, op_b, alu_res;
  logic [RW-1:0]   shamt;
  logic            muldiv_op;
  logic [DW:0]     mul_sum, div_rem, div_diff;
  logic            div_ge;
  logic [4:0]      unused_rs;

  assign op_a      = ReadData1_in;
  assign op_b      = ALUSrc_in ? SignExtdNo_in : ReadData2_in;
  assign shamt     = IC_chunk_in[4:0];
  assign unused_rs = IC_chunk_in[19:15];
  assign muldiv_op = (ALUCntrl_in == OP_MULU) || (ALUCntrl_in == OP_DIVU);
  assign ex_busy   = ((state_q == S_IDLE) && muldiv_op) || (state_q == S_BUSY);

  // Single-cycle ALU result, including HI/LO moves
  always_comb begin
    alu_res = '0;
    case (ALUCntrl_in)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_b << shamt;
      OP_SRL:  alu_res = op_b >> shamt;
      OP_SRA:  alu_res = DW'($signed(op_b) >>> shamt);
      OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(DW-1){1'b0}}, (op_a < op_b)};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Branch/jump redirect, jump wins over branch
  always_comb begin
    PCSrc_out    = 1'b0;
    PCTarget_out = '0;
    if (Jump_in) begin
      PCSrc_out    = 1'b1;
      PCTarget_out = JumpAddr_in;
    end else if (((Branch_in == 2'b01) && (ReadData1_in == ReadData2_in)) ||
                 ((Branch_in == 2'b10) && (ReadData1_in != ReadData2_in))) begin
      PCSrc_out    = 1'b1;
      PCTarget_out = BranchAddr_in;
    end
  end

  // Mul/div FSM: shift-add multiply or restoring divide, one bit per cycle.
  // work_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    div_d    = div_q;
    work_d   = work_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mul_sum  = {1'b0, work_q[2*DW-1:DW]} + {1'b0, (work_q[0] ? a_q : '0)};
    div_rem  = {work_q[2*DW-1:DW], work_q[DW-1]};
    div_ge   = (div_rem >= {1'b0, b_q});
    div_diff = div_rem - {1'b0, b_q};
    case (state_q)
      S_IDLE: begin
        if (muldiv_op) begin
          a_d     = op_a;
          b_d     = op_b;
          div_d   = (ALUCntrl_in == OP_DIVU);
          count_d = '0;
          work_d  = (ALUCntrl_in == OP_DIVU) ? {{DW{1'b0}}, op_a} : {{DW{1'b0}}, op_b};
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (div_q) begin
          work_d = {(div_ge ? div_diff[DW-1:0] : div_rem[DW-1:0]), work_q[DW-2:0], div_ge};
        end else begin
          work_d = {mul_sum, work_q[DW-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(DW - 1)) begin
          hi_d    = work_d[2*DW-1:DW];
          lo_d    = work_d[DW-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // EX/MEM latch contents; a bubble while stalled, no writes from mul/div
  always_comb begin
    alu_d   = '0;
    wdata_d = '0;
    wreg_d  = '0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    mtr_d   = 1'b0;
    rw_d    = 1'b0;
    if (!ex_busy) begin
      alu_d   = alu_res;
      wdata_d = ReadData2_in;
      wreg_d  = RegDest_in ? IC_chunk_in[9:5] : IC_chunk_in[14:10];
      mr_d    = MemRead_in & ~muldiv_op;
      mw_d    = MemWrite_in & ~muldiv_op;
      mtr_d   = MemToReg_in;
      rw_d    = RegWrite_in & ~muldiv_op;
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      work_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      alu_q   <= '0;
      wdata_q <= '0;
      wreg_q  <= '0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      mtr_q   <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      work_q  <= work_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      mtr_q   <= mtr_d;
      rw_q    <= rw_d;
    end
  end

  assign ALUResult_out = alu_q;
  assign WriteData_out = wdata_q;
  assign WriteReg_out  = wreg_q;
  assign MemRead_out   = mr_q;
  assign MemWrite_out  = mw_q;
  assign MemToReg_out  = mtr_q;
  assign RegWrite_out  = rw_q;

endmodule
